// File: rtl/alu_sequencer.sv
// Fetch/read/execute control path driving the 8-bit alu from program memory.
// Define ALU_SEQ_SKIP_EN to build the BTFSC/BTFSS skip logic.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] pm_addr,
    output logic        pm_req,
    input  logic        pm_ack,
    input  logic [13:0] pm_data,
    output logic [6:0]  rf_addr,
    input  logic [7:0]  rf_rdata,
    output logic [7:0]  rf_wdata,
    output logic        rf_we,
    output logic [3:0]  alu_inst,
    output logic [2:0]  alu_bit,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_ans,
    input  logic        alu_carry,
    output logic [7:0]  w_reg,
    output logic        flag_z,
    output logic        flag_c,
    output logic        instr_done
);

    typedef enum logic [1:0] {BOOT, FETCH, READ, EXEC} state_t;

    localparam logic [15:0] C_OPS  = 16'h810C;
    localparam logic [15:0] Z_OPS  = 16'h16FF;
    localparam logic [15:0] LIT_OK = 16'h049D;

    state_t      state, state_nx;
    logic [10:0] pc, pc_nx;
    logic [13:0] ir;
    logic [7:0]  w;
    logic        z, c;

    logic is_byte, is_bit, is_goto, is_lit;
    logic is_bcf, is_bsf, lit_ok, alu_en;
    logic write_w, write_f, upd_z, upd_c, skip;

    assign is_byte = (ir[13:12] == 2'b00);
    assign is_bit  = (ir[13:12] == 2'b01);
    assign is_goto = (ir[13:12] == 2'b10);
    assign is_lit  = (ir[13:12] == 2'b11);
    assign is_bcf  = is_bit && (ir[11:10] == 2'b00);
    assign is_bsf  = is_bit && (ir[11:10] == 2'b01);
    assign lit_ok  = LIT_OK[ir[11:8]];
    assign alu_en  = is_byte || (is_lit && lit_ok);

    assign write_w = (is_byte && !ir[7]) || (is_lit && lit_ok);
    assign write_f = (is_byte && ir[7]) || is_bcf || is_bsf;
    assign upd_z   = alu_en && Z_OPS[alu_inst];
    assign upd_c   = alu_en && C_OPS[alu_inst];

`ifdef ALU_SEQ_SKIP_EN
    // BTFSC (ir[10]=0) skips on a clear bit, BTFSS (ir[10]=1) on a set bit
    assign skip = is_bit && ir[11] && (rf_rdata[ir[9:7]] == ir[10]);
`else
    assign skip = 1'b0;
`endif

    assign pm_addr  = pc;
    assign rf_addr  = ir[6:0];
    assign rf_wdata = alu_ans;
    assign alu_a    = w;
    assign alu_bit  = is_bit ? ir[9:7] : 3'd0;
    assign w_reg    = w;
    assign flag_z   = z;
    assign flag_c   = c;

    always_comb begin
        alu_inst = 4'd0;
        unique case (1'b1)
            is_byte, is_lit: alu_inst = ir[11:8];
            is_bcf:          alu_inst = 4'd14;
            is_bsf:          alu_inst = 4'd13;
            default:         alu_inst = 4'd0;
        endcase
    end

    always_comb begin
        alu_b = 8'd0;
        if (state != BOOT) begin
            unique case (1'b1)
                is_byte, is_bit: alu_b = rf_rdata;
                is_lit:          alu_b = ir[7:0];
                default:         alu_b = 8'd0;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        pm_req     = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        unique case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                pm_req = 1'b1;
                if (pm_ack) state_nx = READ;
            end
            READ: state_nx = EXEC;
            EXEC: begin
                instr_done = 1'b1;
                rf_we      = write_f;
                state_nx   = FETCH;
                if (is_goto)   pc_nx = ir[10:0];
                else if (skip) pc_nx = pc + 11'd2;
                else           pc_nx = pc + 11'd1;
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pc    <= 11'd0;
            ir    <= 14'd0;
            w     <= 8'd0;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && pm_ack) ir <= pm_data;
            if (state == EXEC) begin
                pc <= pc_nx;
                if (write_w) w <= alu_ans;
                if (upd_z)   z <= (alu_ans == 8'd0);
                if (upd_c)   c <= alu_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with behavioural program memory,
// register file and alu around it.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pm_addr;
    logic        pm_req;
    logic        pm_ack = 1'b0;
    logic [13:0] pm_data;
    logic [6:0]  rf_addr;
    logic [7:0]  rf_rdata;
    logic [7:0]  rf_wdata;
    logic        rf_we;
    logic [3:0]  alu_inst;
    logic [2:0]  alu_bit;
    logic [7:0]  alu_a, alu_b, alu_ans;
    logic        alu_carry;
    logic [7:0]  w_reg;
    logic        flag_z, flag_c, instr_done;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .pm_addr(pm_addr), .pm_req(pm_req), .pm_ack(pm_ack), .pm_data(pm_data),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .alu_inst(alu_inst), .alu_bit(alu_bit), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ans(alu_ans), .alu_carry(alu_carry),
        .w_reg(w_reg), .flag_z(flag_z), .flag_c(flag_c), .instr_done(instr_done)
    );

`ifdef ALU_SEQ_SKIP_EN
    localparam logic [10:0] BTFSS_NEXT = 11'd7;
`else
    localparam logic [10:0] BTFSS_NEXT = 11'd6;
`endif

    typedef struct {
        logic [10:0] pc;
        logic        we;
        logic [6:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  w;
        logic        z, c;
        logic [10:0] npc;
    } exp_t;

    logic [13:0] mem [0:2047];
    logic [7:0]  rf [0:127];
    logic [7:0]  rf_init [0:127];
    logic [7:0]  mrf [0:127];
    logic        preload = 1'b0;
    logic        directed = 1'b1;
    int          mode = 1;
    int          checks = 0;
    int          errors = 0;
    int          retired = 0;
    exp_t        q[$];

    logic [10:0] mpc;
    logic [7:0]  mw;
    logic        mz, mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference alu the sequencer is wired to: {carry, result}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] n);
        logic [8:0] r;
        case (op)
            4'd0:  r = {1'b0, b};
            4'd1:  r = 9'd0;
            4'd2:  r = {1'b0, a} + {1'b0, b};
            4'd3:  r = {(b >= a), b - a};
            4'd4:  r = {1'b0, a & b};
            4'd5:  r = {1'b0, b + 8'd1};
            4'd6:  r = {1'b0, b - 8'd1};
            4'd7:  r = {1'b0, a ^ b};
            4'd8:  r = {b[7], b[6:0], b[7]};
            4'd9:  r = {1'b0, ~b};
            4'd10: r = {1'b0, a | b};
            4'd11: r = {1'b0, b[3:0], b[7:4]};
            4'd12: r = {1'b0, a};
            4'd13: r = {1'b0, b | (8'd1 << n)};
            4'd14: r = {1'b0, b & ~(8'd1 << n)};
            default: r = {b[0], b[0], b[7:1]};
        endcase
        return r;
    endfunction

    assign pm_data = mem[pm_addr];

    always_comb begin
        {alu_carry, alu_ans} = alu_f(alu_inst, alu_a, alu_b, alu_bit);
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) rf[i] <= rf_init[i];
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
        end
        rf_rdata <= rf[rf_addr];
    end

    always @(posedge clk) begin
        #1;
        case (mode)
            0: pm_ack = 1'b0;
            1: pm_ack = 1'b1;
            default: pm_ack = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic flags(input logic [3:0] op, input logic [8:0] r);
        if (op inside {4'd2, 4'd3, 4'd8, 4'd15}) mc = r[8];
        if (op inside {[4'd0:4'd7], 4'd9, 4'd10, 4'd12}) mz = (r[7:0] == 8'd0);
    endtask

    task automatic model_step();
        logic [13:0] ir;
        logic [6:0]  f;
        logic [3:0]  op;
        logic [2:0]  n;
        logic [8:0]  r;
        exp_t        e;
        ir = mem[mpc];
        f  = ir[6:0];
        op = ir[11:8];
        n  = ir[9:7];
        e.pc = mpc; e.we = 1'b0; e.wa = f; e.wd = 8'd0;
        e.npc = mpc + 11'd1;
        case (ir[13:12])
            2'd0: begin
                r = alu_f(op, mw, mrf[f], 3'd0);
                if (ir[7]) begin
                    e.we = 1'b1; e.wd = r[7:0]; mrf[f] = r[7:0];
                end else begin
                    mw = r[7:0];
                end
                flags(op, r);
            end
            2'd1: begin
                if (ir[11:10] == 2'd0) begin
                    e.we = 1'b1; e.wd = mrf[f] & ~(8'd1 << n); mrf[f] = e.wd;
                end else if (ir[11:10] == 2'd1) begin
                    e.we = 1'b1; e.wd = mrf[f] | (8'd1 << n); mrf[f] = e.wd;
                end else begin
`ifdef ALU_SEQ_SKIP_EN
                    if ((ir[11:10] == 2'd2 && !mrf[f][n]) ||
                        (ir[11:10] == 2'd3 && mrf[f][n]))
                        e.npc = mpc + 11'd2;
`endif
                end
            end
            2'd2: e.npc = ir[10:0];
            default: begin
                if (op inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd7, 4'd10}) begin
                    r = alu_f(op, mw, ir[7:0], 3'd0);
                    mw = r[7:0];
                    flags(op, r);
                end
            end
        endcase
        e.w = mw; e.z = mz; e.c = mc;
        mpc = e.npc;
        q.push_back(e);
    endtask

    // Model: one expected retirement per accepted fetch
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mrf[i] = rf_init[i];
        end
        if (!reset) begin
            mpc = 11'd0; mw = 8'd0; mz = 1'b0; mc = 1'b0;
        end else if (pm_req && pm_ack) begin
            model_step();
        end
    end

    exp_t cur;
    logic pend = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("w_reg", {24'd0, w_reg}, {24'd0, cur.w});
                chk("flag_z", {31'd0, flag_z}, {31'd0, cur.z});
                chk("flag_c", {31'd0, flag_c}, {31'd0, cur.c});
                chk("next_pc", {21'd0, pm_addr}, {21'd0, cur.npc});
                if (directed) begin
                    if (cur.pc == 11'd1) begin
                        chk("addlw_w", {24'd0, w_reg}, 32'h0C);
                        chk("addlw_c", {31'd0, flag_c}, 32'd1);
                        chk("addlw_z", {31'd0, flag_z}, 32'd0);
                    end
                    if (cur.pc == 11'd2) begin
                        chk("andlw_w", {24'd0, w_reg}, 32'h00);
                        chk("andlw_z", {31'd0, flag_z}, 32'd1);
                        chk("andlw_c", {31'd0, flag_c}, 32'd1);
                    end
                    if (cur.pc == 11'd3)
                        chk("incf_w_kept", {24'd0, w_reg}, 32'h00);
                    if (cur.pc == 11'd5)
                        chk("btfss_next", {21'd0, pm_addr}, {21'd0, BTFSS_NEXT});
                    if (cur.pc == 11'h7FF)
                        chk("pc_wrap", {21'd0, pm_addr}, 32'h000);
                end
                pend = 1'b0;
            end
            if (instr_done) begin
                if (q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("exec_pc", {21'd0, pm_addr}, {21'd0, cur.pc});
                    chk("rf_we", {31'd0, rf_we}, {31'd0, cur.we});
                    if (cur.we) begin
                        chk("rf_addr", {25'd0, rf_addr}, {25'd0, cur.wa});
                        chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, cur.wd});
                    end
                    if (directed && cur.pc == 11'd3) begin
                        chk("incf_we", {31'd0, rf_we}, 32'd1);
                        chk("incf_addr", {25'd0, rf_addr}, 32'h20);
                        chk("incf_data", {24'd0, rf_wdata}, 32'h10);
                    end
                    if (directed && cur.pc == 11'd4) begin
                        chk("bsf_addr", {25'd0, rf_addr}, 32'h21);
                        chk("bsf_data", {24'd0, rf_wdata}, 32'h80);
                    end
                    pend = 1'b1;
                    retired++;
                end
            end
        end
    end

    task automatic reset_outputs(input string tag);
        chk({tag, "_pm_req"}, {31'd0, pm_req}, 32'd0);
        chk({tag, "_pm_addr"}, {21'd0, pm_addr}, 32'd0);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_done"}, {31'd0, instr_done}, 32'd0);
        chk({tag, "_rf_addr"}, {25'd0, rf_addr}, 32'd0);
        chk({tag, "_alu_inst"}, {28'd0, alu_inst}, 32'd0);
        chk({tag, "_alu_bit"}, {29'd0, alu_bit}, 32'd0);
        chk({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
        chk({tag, "_w"}, {24'd0, w_reg}, 32'd0);
        chk({tag, "_z"}, {31'd0, flag_z}, 32'd0);
        chk({tag, "_c"}, {31'd0, flag_c}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        logic found;
        logic [7:0] saved;
        logic [6:0] f;
        reset = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 14'd0;
        mem[0] = 14'h303C;
        mem[1] = 14'h32D0;
        mem[2] = 14'h3400;
        mem[3] = 14'h05A0;
        mem[4] = 14'h17A1;
        mem[5] = 14'h1FA1;
        mem[6] = 14'h3055;
        mem[7] = 14'h27FF;
        mem[11'h7FF] = 14'h3100;
        for (int i = 0; i < 128; i++) rf_init[i] = 8'($urandom_range(1, 255));
        rf_init[7'h20] = 8'h0F;
        rf_init[7'h21] = 8'h00;
        preload = 1'b1;
        @(posedge clk);
        @(posedge clk);
        preload = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_outputs("init");

        reset = 1'b1;
        #1 chk("boot_req", {31'd0, pm_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("fetch_req", {31'd0, pm_req}, 32'd1);
        chk("fetch_addr", {21'd0, pm_addr}, 32'd0);
        n = 1;
        while (!instr_done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_done_lat", n, 3);

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (instr_done && pm_addr == 11'h7FF) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_7ff", {31'd0, found}, 32'd1);
        mode = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, pm_req}, 32'd1);
            chk("stall_addr", {21'd0, pm_addr}, 32'd0);
            if (i == 4) mode = 1;
        end
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (instr_done) break;
        end
        chk("stall_done_lat", n, 3);
        mode = 0;
        directed = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 2048; a++) begin
            f = 7'h20 | 7'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0, 1, 2: mem[a] = {2'b00, 4'($urandom), 1'($urandom), f};
                3, 4:    mem[a] = {2'b01, 2'($urandom), 3'($urandom), f};
                5, 6:    mem[a] = {2'b11, 4'($urandom), 8'($urandom)};
                default: mem[a] = {2'b10, 1'($urandom), 11'($urandom)};
            endcase
        end
        @(negedge clk);
        base = retired;
        mode = 2;
        reset = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (retired >= base + 300) break;
        end
        chk("random_progress", {31'd0, (retired >= base + 300)}, 32'd1);

        mode = 0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        mem[0] = 14'h05A2;
        saved = mrf[7'h22];
        mode = 1;
        @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pm_req && pm_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("p3_fetch", {31'd0, found}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("p3_exec_done", {31'd0, instr_done}, 32'd1);
        chk("p3_exec_we", {31'd0, rf_we}, 32'd1);
        reset = 1'b0;
        #1;
        reset_outputs("exec_rst");
        @(posedge clk);
        #1;
        chk("p3_rf_kept", {24'd0, rf[7'h22]}, {24'd0, saved});
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
